// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch port and a data port onto one
// shared single-cycle memory, and routes each read response back to its owner.
//
// Handshake: a requester holds i_ireq/i_dreq high with its command; the
// command is accepted in any cycle where the matching o_igrant/o_dgrant is
// high (grants are combinational from the requests). At most one grant per
// cycle. A granted read returns exactly one cycle later, flagged by
// o_irvalid/o_drvalid, with data taken straight from i_mrdata.
//
// Ports:
//   i_clk, i_rstn                 clock, async active-low reset
//   i_ireq, i_iaddr               instruction fetch request (read-only)
//   o_igrant, o_irvalid, o_irdata instruction grant / response
//   i_dreq, i_dwe, i_daddr,
//   i_dwdata, i_dbe               data request (read or write)
//   o_dgrant, o_drvalid, o_drdata data grant / response
//   o_maddr, o_mwdata, o_mbe,
//   o_mren, o_mwen, i_mrdata      shared memory command / read data
//   o_dbg_state, o_dbg_streak     response-owner FSM state and streak counter
//                                 (state encoding: IDLE=0, INST=1, DATA=2)
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_STREAK = 4,
  localparam int STREAK_W  = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_ireq,
  input  logic [ADDR_WIDTH-1:0]   i_iaddr,
  output logic                    o_igrant,
  output logic                    o_irvalid,
  output logic [DATA_WIDTH-1:0]   o_irdata,
  input  logic                    i_dreq,
  input  logic                    i_dwe,
  input  logic [ADDR_WIDTH-1:0]   i_daddr,
  input  logic [DATA_WIDTH-1:0]   i_dwdata,
  input  logic [DATA_WIDTH/8-1:0] i_dbe,
  output logic                    o_dgrant,
  output logic                    o_drvalid,
  output logic [DATA_WIDTH-1:0]   o_drdata,
  output logic [ADDR_WIDTH-1:0]   o_maddr,
  output logic [DATA_WIDTH-1:0]   o_mwdata,
  output logic [DATA_WIDTH/8-1:0] o_mbe,
  output logic                    o_mren,
  output logic                    o_mwen,
  input  logic [DATA_WIDTH-1:0]   i_mrdata,
  output logic [1:0]              o_dbg_state,
  output logic [STREAK_W-1:0]     o_dbg_streak
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  state_t              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                streak_full;

  // Data wins contention until it has starved a waiting fetch MAX_STREAK times.
  assign streak_full = (streak_q == STREAK_MAX);
  assign o_igrant    = i_ireq & (~i_dreq | streak_full);
  assign o_dgrant    = i_dreq & ~o_igrant;

  always_comb begin
    o_maddr  = '0;
    o_mwdata = '0;
    o_mbe    = '0;
    o_mren   = 1'b0;
    o_mwen   = 1'b0;
    if (o_igrant) begin
      o_maddr = i_iaddr;
      o_mbe   = '1;
      o_mren  = 1'b1;
    end else if (o_dgrant) begin
      o_maddr  = i_daddr;
      o_mwdata = i_dwdata;
      o_mbe    = i_dbe;
      o_mren   = ~i_dwe;
      o_mwen   = i_dwe;
    end
  end

  // The streak only measures starvation of a fetch that is actually waiting.
  always_comb begin
    streak_d = streak_q;
    if (!i_ireq || o_igrant) begin
      streak_d = '0;
    end else if (o_dgrant && !streak_full) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // Writes complete in the grant cycle, so only reads leave a response owner.
  always_comb begin
    state_d = IDLE;
    if (o_igrant) begin
      state_d = INST;
    end else if (o_dgrant && !i_dwe) begin
      state_d = DATA;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // Decoded straight from the state register so reset clears them at once.
  assign o_irvalid    = (state_q == INST);
  assign o_drvalid    = (state_q == DATA);
  assign o_irdata     = o_irvalid ? i_mrdata : '0;
  assign o_drdata     = o_drvalid ? i_mrdata : '0;
  assign o_dbg_state  = state_q;
  assign o_dbg_streak = streak_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MS = 4;
  localparam int SW = $clog2(MS + 1);

  logic          i_clk = 1'b0;
  logic          i_rstn;
  logic          i_ireq;
  logic [AW-1:0] i_iaddr;
  logic          o_igrant, o_irvalid;
  logic [DW-1:0] o_irdata;
  logic          i_dreq, i_dwe;
  logic [AW-1:0] i_daddr;
  logic [DW-1:0] i_dwdata;
  logic [BW-1:0] i_dbe;
  logic          o_dgrant, o_drvalid;
  logic [DW-1:0] o_drdata;
  logic [AW-1:0] o_maddr;
  logic [DW-1:0] o_mwdata;
  logic [BW-1:0] o_mbe;
  logic          o_mren, o_mwen;
  logic [DW-1:0] i_mrdata;
  logic [1:0]    o_dbg_state;
  logic [SW-1:0] o_dbg_streak;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_STREAK(MS)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_ireq(i_ireq), .i_iaddr(i_iaddr),
    .o_igrant(o_igrant), .o_irvalid(o_irvalid), .o_irdata(o_irdata),
    .i_dreq(i_dreq), .i_dwe(i_dwe), .i_daddr(i_daddr),
    .i_dwdata(i_dwdata), .i_dbe(i_dbe),
    .o_dgrant(o_dgrant), .o_drvalid(o_drvalid), .o_drdata(o_drdata),
    .o_maddr(o_maddr), .o_mwdata(o_mwdata), .o_mbe(o_mbe),
    .o_mren(o_mren), .o_mwen(o_mwen), .i_mrdata(i_mrdata),
    .o_dbg_state(o_dbg_state), .o_dbg_streak(o_dbg_streak)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(negedge i_clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int vectors     = 0;
  int miscompares = 0;

  logic [DW:0] exp_q[$];   // {is_inst, expected read data}
  int          due_q[$];   // cycle on which each response must appear

  int          model_streak;  // data grants taken while a fetch was waiting
  logic [DW-1:0] pending_rd;  // value to drive on i_mrdata this coming cycle

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  // One cycle of stimulus; checks grants and memory command against the
  // reference rules and queues the response that a granted read must produce.
  task automatic drive_cycle(input logic ireq, input logic [AW-1:0] iaddr,
                             input logic dreq, input logic dwe,
                             input logic [AW-1:0] daddr, input logic [DW-1:0] dwdata,
                             input logic [BW-1:0] dbe, input logic [DW-1:0] nxt_rd,
                             output logic dut_ig);
    logic ig, dg;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_be;
    logic e_ren, e_wen;
    @(negedge i_clk);
    i_ireq = ireq; i_iaddr = iaddr;
    i_dreq = dreq; i_dwe = dwe; i_daddr = daddr; i_dwdata = dwdata; i_dbe = dbe;
    i_mrdata = pending_rd;
    ig = ireq && (!dreq || model_streak >= MS);
    dg = dreq && !ig;
    e_addr = ig ? iaddr : (dg ? daddr : '0);
    e_be   = ig ? {BW{1'b1}} : (dg ? dbe : '0);
    e_ren  = ig || (dg && !dwe);
    e_wen  = dg && dwe;
    #2;
    chk("grants", {o_igrant, o_dgrant}, {ig, dg});
    chk("streak", o_dbg_streak, model_streak);
    chk("mem_cmd", {o_mren, o_mwen, o_mbe, o_maddr}, {e_ren, e_wen, e_be, e_addr});
    if (!ig) chk("mem_wdata", o_mwdata, dg ? dwdata : '0);
    if (ig || (dg && !dwe)) begin
      exp_q.push_back({ig, nxt_rd});
      due_q.push_back(cyc + 1);
    end
    pending_rd = nxt_rd;
    if (!ireq || ig) model_streak = 0;
    else if (dg && model_streak < MS) model_streak++;
    dut_ig = o_igrant;
  endtask

  task automatic idle_cycle();
    logic g;
    drive_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, $urandom, g);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [DW:0] e;
    int d;
    forever begin
      @(negedge i_clk);
      #3;
      if (o_irvalid || o_drvalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rvalid", {o_irvalid, o_drvalid}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          d = due_q.pop_front();
          chk("resp_cycle", cyc, d);
          chk("resp_owner", {o_irvalid, o_drvalid}, e[DW] ? 2'b10 : 2'b01);
          chk("resp_rdata", e[DW] ? o_irdata : o_drdata, e[DW-1:0]);
          chk("other_rdata", e[DW] ? o_drdata : o_irdata, '0);
        end
      end else begin
        chk("idle_rdata", {o_irdata, o_drdata}, '0);
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
          e = exp_q.pop_front();
          d = due_q.pop_front();
          chk("missing_rvalid", {o_irvalid, o_drvalid}, e[DW] ? 2'b10 : 2'b01);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic g;
    logic [11:0] pat;
    logic wr;
    i_rstn = 1'b0;
    i_ireq = 1'b0; i_iaddr = '0; i_dreq = 1'b0; i_dwe = 1'b0;
    i_daddr = '0; i_dwdata = '0; i_dbe = '0; i_mrdata = '0;
    model_streak = 0;
    pending_rd = $urandom;

    // Reset: outputs quiet, but grants still follow requests; no response
    // may be registered while reset is held.
    #2;
    chk("rst_rvalid", {o_irvalid, o_drvalid}, 2'b00);
    chk("rst_state", o_dbg_state, 2'd0);
    chk("rst_streak", o_dbg_streak, 0);
    chk("rst_cmd_idle", {o_mren, o_mwen, o_mbe, o_maddr}, '0);
    i_ireq = 1'b1; i_iaddr = 32'h44;
    #1;
    chk("rst_comb_grant", {o_igrant, o_mren, o_maddr}, {1'b1, 1'b1, 32'h44});
    #4;
    chk("rst_no_irvalid", o_irvalid, 1'b0);
    i_ireq = 1'b0;
    #5;
    i_rstn = 1'b1;

    // Single fetch with known read data.
    drive_cycle(1'b1, 32'h10, 1'b0, 1'b0, '0, '0, '0, 32'h0050_0093, g);
    idle_cycle();
    chk("fetch_irvalid", o_irvalid, 1'b1);
    chk("fetch_irdata", o_irdata, 32'h0050_0093);

    // Data write: no response afterwards.
    drive_cycle(1'b0, '0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'h3, $urandom, g);
    idle_cycle();
    chk("write_no_drvalid", o_drvalid, 1'b0);

    // Contention: both request reads for 12 cycles.
    idle_cycle();
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b1, 32'h1000 + 4 * i, 1'b1, 1'b0, 32'h8000 + 4 * i, '0,
                  4'hF, $urandom, g);
      pat[i] = g;
    end
    chk("contention_pattern", pat, 12'b0010_0001_0000);

    // Back-to-back: fetch, data read, fetch.
    idle_cycle();
    drive_cycle(1'b1, 32'h20, 1'b0, 1'b0, '0, '0, '0, $urandom, g);
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 32'h300, '0, 4'hF, $urandom, g);
    drive_cycle(1'b1, 32'h24, 1'b0, 1'b0, '0, '0, '0, $urandom, g);
    idle_cycle();

    // Reset mid-operation: granted read must never return.
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 32'h304, '0, 4'hF, $urandom, g);
    #2;
    i_rstn = 1'b0;
    i_dreq = 1'b0;
    exp_q.delete();
    due_q.delete();
    model_streak = 0;
    @(negedge i_clk);
    #2;
    chk("midrst_drvalid", o_drvalid, 1'b0);
    chk("midrst_state", o_dbg_state, 2'd0);
    i_rstn = 1'b1;
    idle_cycle();
    chk("postrst_drvalid", o_drvalid, 1'b0);
    chk("postrst_state", o_dbg_state, 2'd0);

    // Idle: no requests for 5 cycles.
    for (int i = 0; i < 5; i++) idle_cycle();
    chk("idle_streak", o_dbg_streak, 0);
    chk("idle_state", o_dbg_state, 2'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      wr = ($urandom_range(0, 3) == 0);
      drive_cycle($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 7, wr,
                  $urandom, $urandom, BW'($urandom), $urandom, g);
    end
    idle_cycle();
    idle_cycle();
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of all address buses.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of all data buses.
REQ-003 SHALL have parameter MAX_STREAK, default 4, consecutive data grants allowed while an instruction request waits.
REQ-004 SHALL have port i_clk  in  1  single clock, rising edge.
REQ-005 SHALL have port i_rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_ireq  in  1  instruction-fetch request, read-only.
REQ-007 SHALL have port i_iaddr  in  ADDR_WIDTH  instruction-fetch address.
REQ-008 SHALL have port o_igrant  out  1  instruction request accepted this cycle.
REQ-009 SHALL have port o_irvalid  out  1  instruction read data valid.
REQ-010 SHALL have port o_irdata  out  DATA_WIDTH  instruction read data.
REQ-011 SHALL have port i_dreq  in  1  data request.
REQ-012 SHALL have port i_dwe  in  1  data request is a write (1) or read (0).
REQ-013 SHALL have port i_daddr  in  ADDR_WIDTH  data address.
REQ-014 SHALL have port i_dwdata  in  DATA_WIDTH  data write value.
REQ-015 SHALL have port i_dbe  in  DATA_WIDTH/8  data byte enables.
REQ-016 SHALL have port o_dgrant  out  1  data request accepted this cycle.
REQ-017 SHALL have port o_drvalid  out  1  data read data valid.
REQ-018 SHALL have port o_drdata  out  DATA_WIDTH  data read data.
REQ-019 SHALL have ports o_maddr (ADDR_WIDTH), o_mwdata (DATA_WIDTH), o_mbe (DATA_WIDTH/8), o_mren (1) and o_mwen (1), all outputs, forming the shared memory command.
REQ-020 SHALL have port i_mrdata  in  DATA_WIDTH  shared memory read data, valid the cycle after o_mren.

Function
REQ-021 SHALL accept at most one access per cycle; grants are combinational, and the memory command is driven in the same cycle as its grant.
REQ-022 SHALL, with only i_ireq high, assert o_igrant, set o_mren=1, o_maddr=i_iaddr and o_mbe all-ones.
REQ-023 SHALL, with only i_dreq high, assert o_dgrant, set o_maddr=i_daddr and o_mbe=i_dbe; o_mwen=i_dwe, o_mren=~i_dwe, o_mwdata=i_dwdata.
REQ-024 SHALL, with both requests high, grant data unless the streak counter equals MAX_STREAK, in which case it SHALL grant instruction.
REQ-025 SHALL keep a streak counter that increments (saturating at MAX_STREAK) on each data grant while i_ireq is high, and clears on any instruction grant or any cycle with i_ireq low.
REQ-026 SHALL, with no grant, drive o_mren=o_mwen=0 and o_maddr, o_mwdata and o_mbe to 0.
REQ-027 SHALL track the outstanding-response owner with FSM states IDLE, INST and DATA, registered at each rising edge.
REQ-028 SHALL enter INST after an instruction grant and DATA after a data read grant; otherwise the FSM SHALL enter IDLE (writes never leave a response pending).
REQ-029 SHALL assert o_irvalid exactly in state INST and o_drvalid exactly in state DATA, giving a fixed read latency of 1 cycle after the grant.
REQ-030 SHALL drive o_irdata=i_mrdata when o_irvalid is high and 0 otherwise; o_drdata SHALL follow the same rule with o_drvalid.
REQ-031 SHALL support back-to-back grants every cycle; a new grant in the same cycle that a response is returned is legal.
REQ-032 SHALL NOT let a requester that drops its request without a grant affect the FSM or memory command.
REQ-033 SHALL pass addresses unmodified (no alignment checking or translation).

Reset
REQ-034 SHALL, while i_rstn=0, force the FSM to IDLE, clear the streak counter, and drive o_irvalid=o_drvalid=0 immediately (asynchronously).
REQ-035 SHALL discard any read response pending when reset asserts; no rvalid pulse SHALL appear after reset deasserts for an access granted before reset.
REQ-036 SHALL keep grants and the memory command combinational from requests during reset, with all pending-response state cleared; the outputs SHALL be fully deterministic on the first edge after deassertion.

Verification
REQ-037 SHALL verify single fetch: i_ireq=1, i_iaddr=0x10, i_mrdata=0x00500093 next cycle -> o_igrant=1, o_mren=1, o_maddr=0x10; then o_irvalid=1 with o_irdata=0x00500093.
REQ-038 SHALL verify data write: i_dreq=1, i_dwe=1, i_daddr=0x200, i_dwdata=0xDEADBEEF, i_dbe=0x3 -> o_dgrant=1, o_mwen=1, o_mbe=0x3; no o_drvalid the next cycle.
REQ-039 SHALL verify contention: i_ireq and i_dreq held high (data reads) for 12 cycles with MAX_STREAK=4 -> grant pattern D,D,D,D,I repeating; each rvalid is routed to the matching owner.
REQ-040 SHALL verify back-to-back: fetch, data read and fetch on consecutive cycles -> rvalids on cycles 2, 3 and 4, each carrying the i_mrdata of its cycle.
REQ-041 SHALL verify reset mid-operation: data read granted, then i_rstn=0 before the next edge -> o_drvalid stays 0 and the FSM is IDLE after release.
REQ-042 SHALL verify idle: no requests for 5 cycles -> all memory command outputs are 0 and the streak counter is 0.
